// File: rtl/frame_timestamp_capture_pkg.sv
// Shared constants for the frame timestamp capture block: Avalon register
// addresses, CONTROL bit positions and the layout of a 48-bit stamp entry.
package frame_ts_pkg;

    // Avalon word addresses
    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_TS_LO   = 3'd2;
    localparam logic [2:0] REG_TS_HI   = 3'd3;
    localparam logic [2:0] REG_FRAME   = 3'd4;
    localparam logic [2:0] REG_LEVEL   = 3'd5;
    localparam logic [2:0] REG_LIVE_LO = 3'd6;
    localparam logic [2:0] REG_LIVE_HI = 3'd7;

    // CONTROL register bit indices
    localparam int CTRL_CAP_EN = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLEAR  = 2;

    // Stamp layout: {frame_num[15:0], tick_count[31:0]}
    localparam int STAMP_W   = 48;
    localparam int TICK_W    = 32;
    localparam int FRAME_W   = 16;
    localparam int TS_LO_LSB = 0;
    localparam int TS_HI_LSB = 16;
    localparam int FRAME_LSB = 32;

    // Build one FIFO entry from the frame number and tick count.
    function automatic logic [STAMP_W-1:0] pack_stamp(input logic [FRAME_W-1:0] frame_num,
                                                      input logic [TICK_W-1:0]  tick_count);
        return {frame_num, tick_count};
    endfunction

endpackage

// File: rtl/frame_timestamp_capture_if.sv
// Avalon-MM 16-bit register port of the frame timestamp capture block,
// including the stamp-pending interrupt line.
interface frame_timestamp_capture_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/frame_timestamp_capture_ts_fifo.sv
// Synchronous show-ahead FIFO holding frame stamps. Pop on empty is ignored;
// push while full is ignored unless a pop frees a slot in the same cycle.
// The caller detects dropped pushes for overflow reporting.
module ts_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_s    = (count_r == (AW+1)'(DEPTH));
    assign empty_s   = (count_r == {(AW+1){1'b0}});
    assign do_pop_s  = pop & ~empty_s;
    assign do_push_s = push & (~full_s | do_pop_s);

    // Pointer and occupancy bookkeeping; clear flushes all entries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s && !clear) mem_r[wr_ptr_r] <= din;
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = empty_s;
    assign level = count_r;
endmodule

// File: rtl/frame_timestamp_capture.sv
// Frame timestamp capture: counts interval-timer ticks, synchronises the
// camera frame-valid strobe, and queues {frame_num, tick_count} on each frame
// start for software to pop over a 16-bit Avalon-MM slave.
module frame_timestamp_capture
    import frame_ts_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    frame_timestamp_capture_if.slave  bus,
    input  logic                      tick_in,
    input  logic                      frame_valid_in
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   fval_d_r;
    logic                   tick_d_r;
    logic [TICK_W-1:0]      tick_count_r;
    logic [FRAME_W-1:0]     frame_num_r;
    logic                   cap_en_r;
    logic                   irq_en_r;
    logic                   overflow_r;
    logic [15:0]            shadow_r;
    logic [15:0]            readdata_r;
    logic                   irq_r;

    logic                   wr_s;
    logic                   rd_s;
    logic                   ctrl_wr_s;
    logic                   clear_s;
    logic                   status_wr_s;
    logic                   pop_req_s;
    logic                   fval_s;
    logic                   frame_start_s;
    logic                   tick_event_s;
    logic                   push_req_s;
    logic                   ovf_set_s;
    logic [STAMP_W-1:0]     fifo_head_s;
    logic [STAMP_W-1:0]     head_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [LVL_W-1:0]       fifo_level_s;
    logic [15:0]            rd_next_s;
    logic                   unused_wd_s;

    // Bus decode
    assign wr_s        = bus.chipselect & ~bus.write_n;
    assign rd_s        = bus.chipselect &  bus.write_n;
    assign ctrl_wr_s   = wr_s & (bus.address == REG_CONTROL);
    assign clear_s     = ctrl_wr_s & bus.writedata[CTRL_CLEAR];
    assign status_wr_s = wr_s & (bus.address == REG_STATUS);
    assign pop_req_s   = wr_s & (bus.address == REG_FRAME);
    assign unused_wd_s = ^bus.writedata[15:3];

    // Event detection
    assign fval_s        = sync_r[SYNC_STAGES-1];
    assign frame_start_s = fval_s & ~fval_d_r;
    assign tick_event_s  = tick_in & ~tick_d_r;
    assign push_req_s    = frame_start_s & cap_en_r;
    // A pop while full frees the slot, so only an unmatched push is dropped.
    assign ovf_set_s     = push_req_s & fifo_full_s & ~pop_req_s;

    // Synchronise the camera strobe and keep previous levels for edge detect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r   <= {SYNC_STAGES{1'b0}};
            fval_d_r <= 1'b0;
            tick_d_r <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], frame_valid_in};
            fval_d_r <= fval_s;
            tick_d_r <= tick_in;
        end
    end

    // Free-running tick counter and frame numbering; CLEAR beats any event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_count_r <= 32'h0000_0000;
            frame_num_r  <= 16'h0000;
        end else if (clear_s) begin
            tick_count_r <= 32'h0000_0000;
            frame_num_r  <= 16'h0000;
        end else begin
            if (tick_event_s) tick_count_r <= tick_count_r + 32'd1;
            if (push_req_s)   frame_num_r  <= frame_num_r + 16'd1;
        end
    end

    // CONTROL enables; the CLEAR bit is a pulse and is not stored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_en_r <= 1'b0;
            irq_en_r <= 1'b0;
        end else if (ctrl_wr_s) begin
            cap_en_r <= bus.writedata[CTRL_CAP_EN];
            irq_en_r <= bus.writedata[CTRL_IRQ_EN];
        end
    end

    // Sticky overflow: a new drop outranks a same-cycle STATUS write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r <= 1'b0;
        end else if (clear_s) begin
            overflow_r <= 1'b0;
        end else if (ovf_set_s) begin
            overflow_r <= 1'b1;
        end else if (status_wr_s) begin
            overflow_r <= 1'b0;
        end
    end

    // Latch the upper live count when the lower half is read, for a coherent pair.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_r <= 16'h0000;
        end else if (rd_s && (bus.address == REG_LIVE_LO)) begin
            shadow_r <= tick_count_r[31:16];
        end
    end

    ts_fifo #(
        .WIDTH (STAMP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear_s),
        .push    (push_req_s & ~clear_s),
        .pop     (pop_req_s),
        .din     (pack_stamp(frame_num_r, tick_count_r)),
        .head    (fifo_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level_s)
    );

    assign head_s = fifo_empty_s ? {STAMP_W{1'b0}} : fifo_head_s;

    // Read mux; readdata holds its last value between reads.
    always_comb begin
        rd_next_s = readdata_r;
        if (rd_s) begin
            case (bus.address)
                REG_STATUS:  rd_next_s = {13'b0, overflow_r, fifo_full_s, ~fifo_empty_s};
                REG_CONTROL: rd_next_s = {14'b0, irq_en_r, cap_en_r};
                REG_TS_LO:   rd_next_s = head_s[TS_LO_LSB +: 16];
                REG_TS_HI:   rd_next_s = head_s[TS_HI_LSB +: 16];
                REG_FRAME:   rd_next_s = head_s[FRAME_LSB +: 16];
                REG_LEVEL:   rd_next_s = 16'(fifo_level_s);
                REG_LIVE_LO: rd_next_s = tick_count_r[15:0];
                REG_LIVE_HI: rd_next_s = shadow_r;
                default:     rd_next_s = 16'h0000;
            endcase
        end else begin
            rd_next_s = readdata_r;
        end
    end

    // Registered read data and interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 16'h0000;
            irq_r      <= 1'b0;
        end else begin
            readdata_r <= rd_next_s;
            irq_r      <= ~fifo_empty_s & irq_en_r;
        end
    end

    assign bus.readdata = readdata_r;
    assign bus.irq      = irq_r;
endmodule

// File: tb/tb_frame_timestamp_capture.sv
// Scoreboard bench for frame_timestamp_capture: driver tasks queue the
// expected value of each read/irq sample, a monitor pops and compares.
module tb_frame_timestamp_capture;
    import frame_ts_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic tick_in;
    logic frame_valid_in;
    logic probe;

    always #5 clk = ~clk;

    frame_timestamp_capture_if bus();

    frame_timestamp_capture #(
        .FIFO_DEPTH  (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .tick_in        (tick_in),
        .frame_valid_in (frame_valid_in)
    );

    typedef struct {
        string       name;
        bit          is_irq;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: compare the sample that follows each read or irq probe.
    always @(posedge clk) begin
        bit          rd_now;
        bit          pr_now;
        exp_t        e;
        logic [15:0] act;
        rd_now = bus.chipselect & bus.write_n;
        pr_now = probe;
        if (rd_now || pr_now) begin
            #2;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sample: got %h required none", bus.readdata);
            end else begin
                e   = exp_q.pop_front();
                act = e.is_irq ? {15'b0, bus.irq} : bus.readdata;
                checks++;
                if (act !== e.val)
                    $display("FAIL %s: got %h required %h", e.name, act, e.val);
                if (act !== e.val) errors++;
            end
        end
    end

    task automatic rd(input logic [2:0] a, input logic [15:0] v, input string n);
        @(negedge clk);
        exp_q.push_back('{name: n, is_irq: 1'b0, val: v});
        bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = a;
        @(negedge clk);
        bus.chipselect = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic chk_irq(input logic v, input string n);
        @(negedge clk);
        exp_q.push_back('{name: n, is_irq: 1'b1, val: {15'b0, v}});
        probe = 1'b1;
        @(negedge clk);
        probe = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
    endtask

    task automatic frame();
        @(negedge clk); frame_valid_in = 1'b1;
        repeat (4) @(negedge clk);
        frame_valid_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; tick_in = 1'b0; frame_valid_in = 1'b0; probe = 1'b0;
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 3'd0; bus.writedata = 16'h0000;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        rd(REG_STATUS,  16'h0000, "rst_status");
        rd(REG_CONTROL, 16'h0000, "rst_control");
        rd(REG_LEVEL,   16'h0000, "rst_level");
        rd(REG_TS_LO,   16'h0000, "rst_head_empty");
        chk_irq(1'b0, "rst_irq");

        // 1: basic capture and pop
        wr(REG_CONTROL, 16'h0003);
        repeat (3) tick();
        frame();
        rd(REG_LEVEL, 16'd1,    "t1_level");
        rd(REG_TS_LO, 16'd3,    "t1_ts_lo");
        rd(REG_TS_HI, 16'd0,    "t1_ts_hi");
        rd(REG_FRAME, 16'd0,    "t1_frame");
        rd(REG_STATUS, 16'h0001, "t1_status");
        chk_irq(1'b1, "t1_irq_set");
        wr(REG_FRAME, 16'h0000);
        rd(REG_LEVEL, 16'd0, "t1_level_pop");
        chk_irq(1'b0, "t1_irq_clr");

        // 2: overflow with 10 frames, then drain
        wr(REG_CONTROL, 16'h0007);
        repeat (10) frame();
        rd(REG_LEVEL,  16'd8,    "t2_level_full");
        rd(REG_STATUS, 16'h0007, "t2_status_ovf");
        for (int i = 0; i < 8; i++) begin
            rd(REG_FRAME, 16'(i), $sformatf("t2_frame%0d", i));
            wr(REG_FRAME, 16'h0000);
        end
        rd(REG_LEVEL, 16'd0, "t2_level_drained");
        frame();
        rd(REG_FRAME,  16'd10,   "t2_frame_gap");
        rd(REG_STATUS, 16'h0005, "t2_status_ovf_ne");
        wr(REG_STATUS, 16'h0000);
        rd(REG_STATUS, 16'h0001, "t2_ovf_cleared");
        wr(REG_FRAME, 16'h0000);
        rd(REG_STATUS, 16'h0000, "t2_status_empty");

        // 3: live read coherence and counter wrap
        @(negedge clk) force dut.tick_count_r = 32'h0001_FFFF;
        @(negedge clk) release dut.tick_count_r;
        rd(REG_LIVE_LO, 16'hFFFF, "t3_lo_pre");
        tick();
        rd(REG_LIVE_HI, 16'h0001, "t3_hi_shadow");
        rd(REG_LIVE_LO, 16'h0000, "t3_lo_post");
        rd(REG_LIVE_HI, 16'h0002, "t3_hi_post");
        @(negedge clk) force dut.tick_count_r = 32'hFFFF_FFFF;
        @(negedge clk) release dut.tick_count_r;
        rd(REG_LIVE_LO, 16'hFFFF, "t3_lo_max");
        rd(REG_LIVE_HI, 16'hFFFF, "t3_hi_max");
        tick();
        rd(REG_LIVE_LO, 16'h0000, "t3_lo_wrap");
        rd(REG_LIVE_HI, 16'h0000, "t3_hi_wrap");

        // 4: tick edge coincident with frame start
        wr(REG_CONTROL, 16'h0007);
        repeat (2) tick();
        @(negedge clk); frame_valid_in = 1'b1;
        @(negedge clk);
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
        @(negedge clk); frame_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        rd(REG_TS_LO,   16'd2, "t4_stamp_pre_inc");
        rd(REG_LIVE_LO, 16'd3, "t4_live");
        rd(REG_LEVEL,   16'd1, "t4_level");

        // 5: push and pop together while full
        wr(REG_CONTROL, 16'h0007);
        repeat (8) frame();
        rd(REG_LEVEL,  16'd8,    "t5_level_full");
        rd(REG_STATUS, 16'h0003, "t5_status_full");
        @(negedge clk); frame_valid_in = 1'b1;
        @(negedge clk);
        @(negedge clk); bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = REG_FRAME;
        @(negedge clk); bus.chipselect = 1'b0; bus.write_n = 1'b1;
        @(negedge clk); frame_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        rd(REG_LEVEL,  16'd8,    "t5_level_kept");
        rd(REG_STATUS, 16'h0003, "t5_no_ovf");
        rd(REG_FRAME,  16'd1,    "t5_head");

        // 6: CLEAR with entries, then reset mid-frame
        wr(REG_CONTROL, 16'h0007);
        repeat (4) frame();
        rd(REG_LEVEL, 16'd4, "t6_level4");
        wr(REG_CONTROL, 16'h0007);
        rd(REG_LEVEL,   16'd0,    "t6_level_clr");
        rd(REG_STATUS,  16'h0000, "t6_status_clr");
        rd(REG_CONTROL, 16'h0003, "t6_control");
        frame();
        tick();
        chk_irq(1'b1, "t6_irq_before");
        @(negedge clk); frame_valid_in = 1'b1;
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1; frame_valid_in = 1'b0;
        rd(REG_CONTROL, 16'h0000, "t6_rst_control");
        rd(REG_LEVEL,   16'h0000, "t6_rst_level");
        rd(REG_STATUS,  16'h0000, "t6_rst_status");
        rd(REG_LIVE_LO, 16'h0000, "t6_rst_live");
        chk_irq(1'b0, "t6_rst_irq");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
